// File: rtl/call_request_queue.sv
// -----------------------------------------------------------------------------
// call_request_queue
//
// Converts debounced floor-call buttons into latched pending requests. It picks
// the next target floor SCAN-style, serving the current sweep direction first.
// It offers that target to the motion controller over a valid/ready handshake.
// pending[] drives the call-button LEDs.
//
// Optional feature macro: REQ_CANCEL_EN
//   defined   : pressing an already-pending floor cancels it (toggle). The floor
//               currently held in tgt_floor while an offer is outstanding or
//               accepted is protected from cancellation.
//   undefined : pressing an already-pending floor has no effect.
//
// Reset is synchronous and active-high. Every output comes straight from a
// register.
// -----------------------------------------------------------------------------
module call_request_queue #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  btn_db,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               arrived,
  output logic               tgt_valid,
  output logic [FLOOR_W-1:0] tgt_floor,
  input  logic               tgt_ready,
  output logic               dir_up,
  output logic [FLOORS-1:0]  pending
);

  // Controller phases: nothing in flight, target offered, target accepted.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OFFER    = 2'd1,
    S_WAIT_ARR = 2'd2
  } state_t;

  // Result of a target search.
  // flip : the sweep direction must reverse.
  // floor: the chosen floor.
  typedef struct packed {
    logic               flip;
    logic [FLOOR_W-1:0] floor;
  } pick_t;

  // ---------------------------------------------------------------------------
  // SCAN target selection.
  // The search first looks for the nearest request ahead in the current
  // direction. If there is none, it takes the nearest request behind and
  // reports a direction flip. If nothing lies on either side, the only
  // possible request is the current floor; that floor is returned and the
  // direction is kept.
  // ---------------------------------------------------------------------------
  function automatic pick_t pick_target(
    input logic [FLOORS-1:0]  req,
    input logic [FLOOR_W-1:0] cur,
    input logic               up
  );
    pick_t              res;
    logic               found_above;
    logic               found_below;
    logic [FLOOR_W-1:0] above_f;
    logic [FLOOR_W-1:0] below_f;
    logic [FLOOR_W-1:0] fi;

    found_above = 1'b0;
    found_below = 1'b0;
    above_f     = {FLOOR_W{1'b0}};
    below_f     = {FLOOR_W{1'b0}};

    // Scan downward so the last hit above cur is the lowest one above cur.
    for (int f = FLOORS - 1; f >= 0; f--) begin
      fi = FLOOR_W'(f);
      if (req[f] && (fi > cur)) begin
        found_above = 1'b1;
        above_f     = fi;
      end
    end

    // Scan upward so the last hit below cur is the highest one below cur.
    for (int f = 0; f < FLOORS; f++) begin
      fi = FLOOR_W'(f);
      if (req[f] && (fi < cur)) begin
        found_below = 1'b1;
        below_f     = fi;
      end
    end

    if (up) begin
      if (found_above) begin
        res.flip  = 1'b0;
        res.floor = above_f;
      end else if (found_below) begin
        res.flip  = 1'b1;
        res.floor = below_f;
      end else begin
        res.flip  = 1'b0;
        res.floor = cur;
      end
    end else begin
      if (found_below) begin
        res.flip  = 1'b0;
        res.floor = below_f;
      end else if (found_above) begin
        res.flip  = 1'b1;
        res.floor = above_f;
      end else begin
        res.flip  = 1'b0;
        res.floor = cur;
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [FLOORS-1:0]  btn_q;
  logic [FLOORS-1:0]  pending_q,   pending_d;
  logic               tgt_valid_q, tgt_valid_d;
  logic [FLOOR_W-1:0] tgt_floor_q, tgt_floor_d;
  logic               dir_up_q,    dir_up_d;

  logic [FLOORS-1:0]  press_s;
  logic [FLOORS-1:0]  clr_s;
  logic               at_tgt_s;
  pick_t              pick_s;
`ifdef REQ_CANCEL_EN
  logic [FLOORS-1:0]  hold_s;
  logic [FLOORS-1:0]  toggle_s;
`endif

  // The search always sees the latched requests as they stand this cycle.
  assign pick_s = pick_target(pending_q, cur_floor, dir_up_q);

  // An arrival at the floor currently held as target.
  // Only meaningful outside IDLE.
  assign at_tgt_s = arrived && (cur_floor == tgt_floor_q);

  // Request latch: set on button rising edges, clear on arrival. Clear wins.
  always_comb begin
    press_s = btn_db & ~btn_q;
    clr_s   = {FLOORS{1'b0}};
    // An out-of-range cur_floor matches no bit, so such an arrival clears nothing.
    for (int f = 0; f < FLOORS; f++) begin
      if (arrived && (cur_floor == FLOOR_W'(f))) begin
        clr_s[f] = 1'b1;
      end else begin
        clr_s[f] = 1'b0;
      end
    end
`ifdef REQ_CANCEL_EN
    hold_s = {FLOORS{1'b0}};
    // The floor behind an outstanding or accepted target cannot be cancelled.
    for (int f = 0; f < FLOORS; f++) begin
      if ((state_q != S_IDLE) && (tgt_floor_q == FLOOR_W'(f))) begin
        hold_s[f] = 1'b1;
      end else begin
        hold_s[f] = 1'b0;
      end
    end
    // A press on a free floor sets its bit.
    // A press on a pending, unprotected floor clears its bit.
    toggle_s  = press_s & (~pending_q | ~hold_s);
    pending_d = (pending_q ^ toggle_s) & ~clr_s;
`else
    pending_d = (pending_q | press_s) & ~clr_s;
`endif
  end

  // Handshake FSM next-state logic: choose the target, offer it, and track
  // it until the car arrives there.
  always_comb begin
    state_d     = state_q;
    tgt_valid_d = tgt_valid_q;
    tgt_floor_d = tgt_floor_q;
    dir_up_d    = dir_up_q;

    case (state_q)
      S_IDLE: begin
        if (pending_q != {FLOORS{1'b0}}) begin
          tgt_floor_d = pick_s.floor;
          dir_up_d    = pick_s.flip ? ~dir_up_q : dir_up_q;
          tgt_valid_d = 1'b1;
          state_d     = S_OFFER;
        end else begin
          tgt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_OFFER: begin
        // Reaching the offered floor before it is accepted withdraws the
        // offer. This check takes priority over a same-cycle handshake.
        if (at_tgt_s) begin
          tgt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (tgt_ready) begin
          tgt_valid_d = 1'b0;
          state_d     = S_WAIT_ARR;
        end else begin
          tgt_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end

      S_WAIT_ARR: begin
        tgt_valid_d = 1'b0;
        // Arrivals elsewhere are pass-by service and are handled by the latch.
        if (at_tgt_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_ARR;
        end
      end

      default: begin
        tgt_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset. Reset drops any in-flight target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      btn_q       <= {FLOORS{1'b0}};
      pending_q   <= {FLOORS{1'b0}};
      tgt_valid_q <= 1'b0;
      tgt_floor_q <= {FLOOR_W{1'b0}};
      dir_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_db;
      pending_q   <= pending_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_floor_q <= tgt_floor_d;
      dir_up_q    <= dir_up_d;
    end
  end

  assign tgt_valid = tgt_valid_q;
  assign tgt_floor = tgt_floor_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_call_request_queue.sv
// Bench for call_request_queue: directed scenarios followed by randomized
// traffic. Both are compared cycle by cycle against a behavioural model of
// the request queue.
module tb_call_request_queue;

  localparam int FLOORS  = 8;
  localparam int FLOOR_W = 3;

  logic               clk;
  logic               rst;
  logic [FLOORS-1:0]  btn_db;
  logic [FLOOR_W-1:0] cur_floor;
  logic               arrived;
  logic               tgt_valid;
  logic [FLOOR_W-1:0] tgt_floor;
  logic               tgt_ready;
  logic               dir_up;
  logic [FLOORS-1:0]  pending;

  int checks = 0;
  int errors = 0;

  // Model state
  bit [FLOORS-1:0] m_pend;
  bit [FLOORS-1:0] m_btn_prev;
  bit              m_valid;
  int              m_tgt;
  bit              m_up;
  bit              m_has;   // a target is offered or accepted
  bit              m_acc;   // that target has been accepted

  call_request_queue #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_db    (btn_db),
    .cur_floor (cur_floor),
    .arrived   (arrived),
    .tgt_valid (tgt_valid),
    .tgt_floor (tgt_floor),
    .tgt_ready (tgt_ready),
    .dir_up    (dir_up),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, using the inputs currently driven.
  task automatic model_step();
    bit [FLOORS-1:0] press;
    bit [FLOORS-1:0] old;
    int c, above, below;
    if (rst) begin
      m_pend = '0; m_btn_prev = '0; m_valid = 0; m_tgt = 0;
      m_up = 1; m_has = 0; m_acc = 0;
      return;
    end
    c          = int'(cur_floor);
    press      = btn_db & ~m_btn_prev;
    m_btn_prev = btn_db;
    old        = m_pend;
    for (int f = 0; f < FLOORS; f++) begin
      if (press[f]) begin
`ifdef REQ_CANCEL_EN
        if (!old[f]) m_pend[f] = 1;
        else if (!(m_has && m_tgt == f)) m_pend[f] = 0;
`else
        m_pend[f] = 1;
`endif
      end
    end
    if (arrived && c < FLOORS) m_pend[c] = 0;

    if (!m_has) begin
      if (old != 0) begin
        above = -1; below = -1;
        for (int d = 1; d < FLOORS; d++) begin
          if (above < 0 && c + d < FLOORS && old[c + d]) above = c + d;
          if (below < 0 && c - d >= 0 && old[c - d]) below = c - d;
        end
        if (m_up) begin
          if (above >= 0) m_tgt = above;
          else if (below >= 0) begin m_tgt = below; m_up = 0; end
          else m_tgt = c;
        end else begin
          if (below >= 0) m_tgt = below;
          else if (above >= 0) begin m_tgt = above; m_up = 1; end
          else m_tgt = c;
        end
        m_has = 1; m_acc = 0; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end else if (!m_acc) begin
      if (arrived && c == m_tgt) begin m_has = 0; m_valid = 0; end
      else if (tgt_ready) begin m_acc = 1; m_valid = 0; end
    end else begin
      if (arrived && c == m_tgt) m_has = 0;
    end
  endtask

  // One clock with model update and full output comparison.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".pending"},   32'(pending),   32'(m_pend));
    check({tag, ".tgt_valid"}, 32'(tgt_valid), 32'(m_valid));
    check({tag, ".tgt_floor"}, 32'(tgt_floor), 32'(m_tgt));
    check({tag, ".dir_up"},    32'(dir_up),    32'(m_up));
  endtask

  task automatic idle_inputs();
    rst = 0; btn_db = '0; arrived = 0; tgt_ready = 0;
  endtask

  initial begin
    // T1: button held through reset counts as a press once reset drops.
    rst = 1; btn_db = 8'h04; cur_floor = 3'd0; arrived = 0; tgt_ready = 0;
    repeat (3) cycle("t1_rst");
    check("t1_rst_pend", 32'(pending), 32'h0);
    check("t1_rst_dir",  32'(dir_up),  32'h1);
    rst = 0;
    cycle("t1_rel");
    check("t1_pend", 32'(pending), 32'h04);
    check("t1_val0", 32'(tgt_valid), 32'h0);
    cycle("t1_pick");
    check("t1_val1", 32'(tgt_valid), 32'h1);
    check("t1_tgt",  32'(tgt_floor), 32'd2);
    btn_db = '0; tgt_ready = 1;
    cycle("t1_hs");
    check("t1_hs_val", 32'(tgt_valid), 32'h0);
    tgt_ready = 0; cur_floor = 3'd2; arrived = 1;
    cycle("t1_arr");
    arrived = 0;

    // T2: SCAN order 5, then 6, then reverse to 1.
    cur_floor = 3'd3; btn_db = 8'h62;
    cycle("t2_press");
    btn_db = '0;
    cycle("t2_pick5");
    check("t2_tgt5", 32'(tgt_floor), 32'd5);
    tgt_ready = 1; cycle("t2_hs5"); tgt_ready = 0;
    cur_floor = 3'd5; arrived = 1; cycle("t2_arr5"); arrived = 0;
    check("t2_pend42", 32'(pending), 32'h42);
    cycle("t2_pick6");
    check("t2_tgt6", 32'(tgt_floor), 32'd6);
    tgt_ready = 1; cycle("t2_hs6"); tgt_ready = 0;
    cur_floor = 3'd6; arrived = 1; cycle("t2_arr6"); arrived = 0;
    cycle("t2_pick1");
    check("t2_tgt1", 32'(tgt_floor), 32'd1);
    check("t2_dir0", 32'(dir_up),    32'h0);
    check("t2_val",  32'(tgt_valid), 32'h1);

    // T3: offer stays stable while ready is low and new presses latch.
    for (int i = 0; i < 10; i++) begin
      btn_db = i[0] ? 8'h00 : (8'h80 >> ((i / 2) % 3));
      cycle("t3_hold");
      check("t3_val", 32'(tgt_valid), 32'h1);
      check("t3_tgt", 32'(tgt_floor), 32'd1);
    end
    check("t3_pend", 32'(pending), 32'hE2);

    // T4: pass-by service in WAIT_ARR; a same-cycle press and arrival clears.
    idle_inputs(); rst = 1; cycle("t4_rst"); rst = 0;
    cur_floor = 3'd5; btn_db = 8'h50; cycle("t4_press");
    btn_db = '0; cycle("t4_pick");
    check("t4_tgt6", 32'(tgt_floor), 32'd6);
    tgt_ready = 1; cycle("t4_hs"); tgt_ready = 0;
    cur_floor = 3'd4; arrived = 1; cycle("t4_pass4");
    check("t4_pend", 32'(pending), 32'h40);
    cur_floor = 3'd2; btn_db = 8'h04; cycle("t4_pc2");
    check("t4_pend2", 32'(pending), 32'h40);
    btn_db = '0; arrived = 0; cycle("t4_wait");
    check("t4_still", 32'(tgt_valid), 32'h0);
    cur_floor = 3'd6; arrived = 1; cycle("t4_arr6"); arrived = 0;
    check("t4_empty", 32'(pending), 32'h0);

    // T5: second press on a pending floor; press on the target floor.
    idle_inputs(); rst = 1; cycle("t5_rst"); rst = 0;
    cur_floor = 3'd0; btn_db = 8'h20; cycle("t5_p5");
    btn_db = '0; cycle("t5_pick");
    btn_db = 8'h02; cycle("t5_p1a");
    btn_db = '0; cycle("t5_rel");
    btn_db = 8'h02; cycle("t5_p1b");
`ifdef REQ_CANCEL_EN
    check("t5_cancel", 32'(pending[1]), 32'h0);
`else
    check("t5_idem", 32'(pending[1]), 32'h1);
`endif
    btn_db = '0; cycle("t5_rel2");
    btn_db = 8'h20; cycle("t5_ptgt");
    check("t5_tgtkeep", 32'(pending[5]), 32'h1);
    check("t5_tgt",     32'(tgt_floor),  32'd5);

    // T6: reset while a target is accepted and every floor is pending.
    idle_inputs(); rst = 1; cycle("t6_rst0"); rst = 0;
    cur_floor = 3'd0; btn_db = 8'hFF; cycle("t6_all");
    btn_db = '0; cycle("t6_pick");
    tgt_ready = 1; cycle("t6_hs"); tgt_ready = 0;
    cycle("t6_wait");
    check("t6_pendFF", 32'(pending), 32'hFF);
    rst = 1; cycle("t6_rst");
    check("t6_pend0", 32'(pending),   32'h0);
    check("t6_val0",  32'(tgt_valid), 32'h0);
    check("t6_dir1",  32'(dir_up),    32'h1);
    rst = 0; btn_db = 8'h08; cycle("t6_p3");
    btn_db = '0; cycle("t6_idle");
    check("t6_newtgt", 32'(tgt_floor), 32'd3);
    check("t6_newval", 32'(tgt_valid), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) btn_db = FLOORS'($urandom);
      cur_floor = FLOOR_W'($urandom_range(0, FLOORS - 1));
      arrived   = ($urandom_range(0, 4) == 0);
      tgt_ready = ($urandom_range(0, 1) == 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
